// File: rtl/xif_result_queue.sv
// xif_result_queue: circular result FIFO for the XIF result interface.
// Killed entries stay queued with live=0 and are silently dropped when they reach the head.
module xif_result_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int FLEN        = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [X_ID_WIDTH-1:0]              in_id,
    input  logic [FLEN-1:0]                    in_data,
    input  logic [4:0]                         in_rd,
    input  logic                               in_we,
    input  logic                               in_exc,
    input  logic [5:0]                         in_exccode,
    input  logic                               commit_valid,
    input  logic [X_ID_WIDTH-1:0]              commit_id,
    input  logic                               commit_kill,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [X_ID_WIDTH-1:0]              result_id,
    output logic [FLEN-1:0]                    result_data,
    output logic [4:0]                         result_rd,
    output logic                               result_we,
    output logic                               result_exc,
    output logic [5:0]                         result_exccode,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
    output logic                               overflow
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);
    localparam int EW = X_ID_WIDTH + FLEN + 13;

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [QUEUE_DEPTH-1:0] live_q, live_d;
    logic [EW-1:0]          mem_q [QUEUE_DEPTH];
    logic [EW-1:0]          mem_d [QUEUE_DEPTH];
    logic                   overflow_q, overflow_d;
    logic                   push, pop, kill;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready     = count_q < CW'(QUEUE_DEPTH);
    assign result_valid = (count_q != '0) && live_q[rd_ptr_q];
    assign {result_id, result_data, result_rd, result_we, result_exc, result_exccode} = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow     = overflow_q;

    always_comb begin
        push = in_valid && in_ready;
        // a dead head is dropped regardless of result_ready
        pop  = (count_q != '0) && (!live_q[rd_ptr_q] || result_ready);
        kill = commit_valid && commit_kill;
        live_d = live_q;
        mem_d  = mem_q;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (kill && mem_q[i][EW-1 -: X_ID_WIDTH] == commit_id) live_d[i] = 1'b0;
        if (pop) live_d[rd_ptr_q] = 1'b0;
        if (push) begin
            live_d[wr_ptr_q] = !(kill && in_id == commit_id);
            mem_d[wr_ptr_q]  = {in_id, in_data, in_rd, in_we, in_exc, in_exccode};
        end
        rd_ptr_d   = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? nxt(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q || (in_valid && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            live_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            live_q     <= live_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_xif_result_queue.sv
// tb_xif_result_queue: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_xif_result_queue;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, in_we = 0, in_exc = 0;
    logic [3:0]  in_id = 0, commit_id = 0, result_id;
    logic [31:0] in_data = 0, result_data;
    logic [4:0]  in_rd = 0, result_rd;
    logic [5:0]  in_exccode = 0, result_exccode;
    logic        commit_valid = 0, commit_kill = 0;
    logic        result_valid, result_ready = 0, result_we, result_exc;
    logic [2:0]  count;
    logic        overflow;

    xif_result_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_data(in_data), .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc), .in_exccode(in_exccode),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
        .result_exc(result_exc), .result_exccode(result_exccode), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we, exc;
        logic [5:0]  code;
        bit          live;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [3:0]  iid;
        logic [31:0] idata;
        logic [4:0]  ird;
        logic        rr;
        int          e_cnt;
        logic        e_ir, e_rv;
        logic [3:0]  e_id;
        logic [31:0] e_data;
        logic        e_ovf;
    } vec_t;

    ent_t       mq[$];
    logic [3:0] got[$];
    bit         ovf_m = 0, seen = 0;
    logic [3:0] watch = 4'hF;
    int         n_chk = 0, n_fail = 0;
    vec_t       tbl[13];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic [3:0] iid, input logic [31:0] d,
                          input logic [4:0] r, input logic rr, input logic cv,
                          input logic ck, input logic [3:0] cid);
        in_valid = iv; in_id = iid; in_data = d; in_rd = r;
        in_we = d[0]; in_exc = d[1]; in_exccode = d[7:2];
        result_ready = rr; commit_valid = cv; commit_kill = ck; commit_id = cid;
    endtask

    task automatic model_check();
        chk("count", count, mq.size());
        chk("in_ready", in_ready, mq.size() < 4);
        chk("overflow", overflow, ovf_m);
        if (mq.size() > 0) begin
            chk("result_valid", result_valid, mq[0].live);
            if (mq[0].live) begin
                chk("result_id", result_id, mq[0].id);
                chk("result_data", result_data, mq[0].data);
                chk("result_rd", result_rd, mq[0].rd);
                chk("result_we", result_we, mq[0].we);
                chk("result_exc", result_exc, mq[0].exc);
                chk("result_exccode", result_exccode, mq[0].code);
            end
        end else chk("result_valid", result_valid, 0);
        if (result_valid && result_ready) got.push_back(result_id);
        if (result_valid && result_id == watch) seen = 1;
    endtask

    task automatic step();
        bit pop, push, k;
        int sz;
        #1;
        model_check();
        sz   = mq.size();
        push = in_valid && sz < 4;
        pop  = 0;
        if (sz > 0) pop = !mq[0].live || result_ready;
        k = commit_valid && commit_kill;
        if (in_valid && sz >= 4) ovf_m = 1;
        @(posedge clk);
        if (pop) mq.delete(0);
        if (k) foreach (mq[i]) if (mq[i].id == commit_id) mq[i].live = 0;
        if (push) mq.push_back('{in_id, in_data, in_rd, in_we, in_exc, in_exccode, !(k && in_id == commit_id)});
        #1;
    endtask

    task automatic rst();
        reset = 1;
        set_in(1, 4'd7, 32'hDEAD, 5'd1, 1, 1, 1, 4'd0);
        @(posedge clk);
        #1;
        reset = 0;
        mq.delete();
        ovf_m = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int k;
        tbl[0]  = '{1, 4'd3, 32'h3F800000, 5'd5, 1, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 4'd0, 32'h0, 5'd0, 1, 1, 1, 1, 4'd3, 32'h3F800000, 0};
        tbl[2]  = '{0, 4'd0, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 4'd0, 32'h100, 5'd1, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 4'd1, 32'h101, 5'd2, 0, 1, 1, 1, 4'd0, 32'h100, 0};
        tbl[5]  = '{1, 4'd2, 32'h102, 5'd3, 0, 2, 1, 1, 4'd0, 32'h100, 0};
        tbl[6]  = '{1, 4'd3, 32'h103, 5'd4, 0, 3, 1, 1, 4'd0, 32'h100, 0};
        tbl[7]  = '{1, 4'd4, 32'h104, 5'd6, 0, 4, 0, 1, 4'd0, 32'h100, 0};
        tbl[8]  = '{0, 4'd0, 32'h0, 5'd0, 1, 4, 0, 1, 4'd0, 32'h100, 1};
        tbl[9]  = '{0, 4'd0, 32'h0, 5'd0, 1, 3, 1, 1, 4'd1, 32'h101, 1};
        tbl[10] = '{0, 4'd0, 32'h0, 5'd0, 1, 2, 1, 1, 4'd2, 32'h102, 1};
        tbl[11] = '{0, 4'd0, 32'h0, 5'd0, 1, 1, 1, 1, 4'd3, 32'h103, 1};
        tbl[12] = '{0, 4'd0, 32'h0, 5'd0, 0, 0, 1, 0, 4'd0, 32'h0, 1};

        rst();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result_valid", result_valid, 0);
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].iv, tbl[i].iid, tbl[i].idata, tbl[i].ird, tbl[i].rr, 0, 0, 0);
            #1;
            chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d_result_valid", i), result_valid, tbl[i].e_rv);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].e_ovf);
            if (tbl[i].e_rv) begin
                chk($sformatf("vec%0d_result_id", i), result_id, tbl[i].e_id);
                chk($sformatf("vec%0d_result_data", i), result_data, tbl[i].e_data);
            end
            step();
        end

        // kill skip, with a same-cycle push of the killed id
        rst();
        for (int i = 1; i <= 3; i++) begin
            set_in(1, 4'(i), 32'h200 + i, 5'(i), 0, 0, 0, 0);
            step();
        end
        set_in(1, 4'd2, 32'h222, 5'd9, 0, 1, 1, 4'd2);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        got.delete();
        watch = 4'd2;
        seen = 0;
        repeat (6) step();
        watch = 4'hF;
        chk("kill_pop_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("kill_first", got[0], 1);
            chk("kill_second", got[1], 3);
        end
        chk("kill_id2_visible", seen, 0);
        chk("kill_drained", count, 0);

        // push and pop together at full
        rst();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 4'(i), 32'h300 + i, 5'(i), 0, 0, 0, 0);
            step();
        end
        set_in(1, 4'd9, 32'h399, 5'd9, 1, 0, 0, 0);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        step();
        chk("full_after_pop", count, 3);
        set_in(1, 4'd9, 32'h399, 5'd9, 0, 0, 0, 0);
        step();
        chk("full_refill", count, 4);

        // reset mid-operation
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("pre_reset_count", count, 3);
        rst();
        #1;
        chk("mid_reset_count", count, 0);
        chk("mid_reset_valid", result_valid, 0);
        chk("mid_reset_overflow", overflow, 0);
        chk("mid_reset_in_ready", in_ready, 1);
        step();

        // wrap-around stream with toggling result_ready
        rst();
        got.delete();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            logic iv;
            iv = (k < 10) && (mq.size() < 4);
            set_in(iv, 4'(k), 32'hA000 + k, 5'(k), c[0], 0, 0, 0);
            step();
            if (iv) k++;
        end
        chk("wrap_count", got.size(), 10);
        foreach (got[i]) chk($sformatf("wrap_order%0d", i), got[i], i);
        chk("wrap_overflow", overflow, 0);

        // random traffic
        for (int r = 0; r < 4; r++) begin
            rst();
            repeat (150) begin
                set_in($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), $urandom, 5'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/xif_result_queue.md
XIF_RESULT_QUEUE -- requirements
Module: xif_result_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, number of result entries held; legal range 2..16.
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, width of the offloaded-instruction id.
REQ-003 SHALL have parameter FLEN, default 32, width of result data.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, FPU pipeline offers a completed result.
REQ-007 SHALL have port in_ready, output, 1, the queue can accept a result this cycle.
REQ-008 SHALL have port in_id, input, X_ID_WIDTH, id of the offered result.
REQ-009 SHALL have port in_data, input, FLEN, result data.
REQ-010 SHALL have port in_rd, input, 5, destination register.
REQ-011 SHALL have port in_we, input, 1, writeback to the core register file required.
REQ-012 SHALL have port in_exc, input, 1, the instruction raised a synchronous exception.
REQ-013 SHALL have port in_exccode, input, 6, exception code.
REQ-014 SHALL have port commit_valid, input, 1, commit interface strobe.
REQ-015 SHALL have port commit_id, input, X_ID_WIDTH, id being committed or killed.
REQ-016 SHALL have port commit_kill, input, 1, the committed id is killed.
REQ-017 SHALL have ports result_valid (output, 1) and result_ready (input, 1), the XIF result handshake.
REQ-018 SHALL have ports result_id, result_data, result_rd, result_we, result_exc and result_exccode as outputs, with the same widths as the matching in_* ports, driven from the head entry.
REQ-019 SHALL have port count, output, $clog2(QUEUE_DEPTH+1), number of occupied entries, including killed entries.
REQ-020 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-021 SHALL be a circular FIFO with read and write pointers that wrap from QUEUE_DEPTH-1 to 0; QUEUE_DEPTH is not required to be a power of two.
REQ-022 SHALL drive in_ready = (count < QUEUE_DEPTH), with no combinational path from result_ready.
REQ-023 SHALL perform a push when in_valid && in_ready: write the entry at the write pointer with live=1, then advance the write pointer.
REQ-024 SHALL drive result_valid = (count > 0) && live[head]; the result_* outputs are registered entry contents.
REQ-025 SHALL achieve a latency of exactly 1 cycle: a push into an empty queue in cycle N gives result_valid=1 in cycle N+1.
REQ-026 SHALL perform a pop when result_valid && result_ready, advancing the read pointer.
REQ-027 SHALL, when count > 0 and live[head]==0, auto-pop the head in that cycle, whatever the value of result_ready; result_valid stays 0 that cycle.
REQ-028 SHALL hold result_valid and the result_* outputs stable while result_valid && !result_ready.
REQ-029 SHALL, on commit_valid && commit_kill, clear live for every occupied entry whose id equals commit_id.
REQ-030 SHALL also clear live for a push in the same cycle whose in_id equals a killed commit_id, so the entry is stored with live=0.
REQ-031 SHALL ignore commit_valid with commit_kill=0.
REQ-032 SHALL allow a push and a pop (or auto-pop) in the same cycle; count is then unchanged and both pointers advance.
REQ-033 SHALL, when full, allow a same-cycle pop but still hold in_ready=0, with no pass-through.
REQ-034 SHALL set overflow when in_valid && !in_ready, and hold it until reset; the offered data is dropped and the queue is unchanged.
REQ-035 SHALL, when empty, drive the result_* outputs to the last popped values or zero; they are don't-care while result_valid=0.

Reset
REQ-036 SHALL, with reset high at a clock edge, set count=0, both pointers=0, every live bit=0, overflow=0 and result_valid=0.
REQ-037 SHALL have in_ready=1 in the cycle after reset.
REQ-038 SHALL, when reset is asserted mid-operation, discard all queued entries and ignore any same-cycle push, pop or kill.
REQ-039 SHALL keep the result data registers un-reset; result_valid gates their use.

Verification
REQ-040 SHALL cover basic flow: push id=3, data=0x3F800000, rd=5 into an empty queue with result_ready=1 -> result_valid=1 next cycle with id=3, data=0x3F800000, rd=5; count returns to 0 the cycle after.
REQ-041 SHALL cover fill and backpressure: with result_ready=0 push 4 results (ids 0..3) -> count=4, in_ready=0; a 5th push -> overflow=1 and count stays 4; then result_ready=1 -> ids 0,1,2,3 pop in order over 4 cycles.
REQ-042 SHALL cover kill skip: queue ids 1,2,3; commit_valid=1, commit_kill=1, commit_id=2 -> pops yield ids 1 then 3; id 2 never shows result_valid=1, and count drops by 1 in the auto-pop cycle.
REQ-043 SHALL cover simultaneous push and pop at full: count=4, result_ready=1, in_valid=1 -> no push (in_ready=0), count=3; next cycle push accepted and count=4.
REQ-044 SHALL cover wrap-around: stream 10 results through with result_ready toggling every cycle -> output order equals input order and no overflow.
REQ-045 SHALL cover reset mid-operation: with count=3, assert reset for 1 cycle -> count=0, result_valid=0, overflow=0 and in_ready=1 next cycle.
